// File: rtl/ssr_pkg.sv
// Shared SSR4/SSR6 definitions: lane counts, ce cadence, lock states.
// Used by the gearboxes and the ce cadence tracker.
package ssr_pkg;

  localparam int SSR4_N    = 4;
  localparam int SSR6_N    = 6;
  localparam int CE_PERIOD = 3;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } gbx_state_t;

  // ce is low on phase 0 only: cadence 0,1,1
  function automatic logic ce_expected(input logic [1:0] phase);
    return (phase != 2'd0);
  endfunction

endpackage

// File: rtl/ssr_ce_tracker.sv
// Locks to the 0,1,1 ce cadence, tracks phase, flags sticky cadence errors.
// Phase/locked are registered; o_viol is combinational for the current clock.
module ssr_ce_tracker
  import ssr_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce,
  output logic [1:0] o_phase,
  output logic       o_locked,
  output logic       o_viol,
  output logic       o_err
);

  gbx_state_t r_state;
  gbx_state_t w_state_nxt;
  logic [1:0] r_phase;
  logic [1:0] w_phase_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       w_viol;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= UNLOCKED;
      r_phase <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_err_nxt   = r_err;
    w_viol      = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (!i_ce) begin
          w_state_nxt = LOCKED;
          w_phase_nxt = 2'd1;
        end
      end
      LOCKED: begin
        w_viol = (i_ce != ce_expected(r_phase));
        // the violating clock never relocks, even with ce low
        if (w_viol) begin
          w_state_nxt = UNLOCKED;
          w_phase_nxt = 2'd0;
          w_err_nxt   = 1'b1;
        end else if (r_phase == 2'(CE_PERIOD - 1)) begin
          w_phase_nxt = 2'd0;
        end else begin
          w_phase_nxt = r_phase + 2'd1;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  assign o_phase  = r_phase;
  assign o_locked = (r_state == LOCKED);
  assign o_viol   = w_viol;
  assign o_err    = r_err;

endmodule

// File: rtl/ssr6_to_ssr4_gearbox.sv
// 6-sample/clock (ce 2-of-3) to continuous 4-sample/clock gearbox, bit-exact.
// Latency 2 clocks from A presentation; no backpressure, errors zero the output.
module ssr6_to_ssr4_gearbox
  import ssr_pkg::*;
#(
  parameter int NBITS = 13
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ce_i,
  input  logic [SSR6_N-1:0][NBITS-1:0] dat_i,
  output logic [SSR4_N-1:0][NBITS-1:0] dat_o,
  output logic                        valid_o,
  output logic                        frame_o,
  output logic                        err_o
);

  localparam int NIN  = SSR6_N;
  localparam int NOUT = SSR4_N;

  logic [1:0] w_phase;
  logic       w_locked;
  logic       w_viol;
  logic       w_err;
  logic       w_hit;

  logic [NIN-1:0][NBITS-1:0]  r_hold_a;
  logic [NIN-1:0][NBITS-1:0]  r_hold_b;
  logic [NOUT-1:0][NBITS-1:0] r_dat;
  logic                       r_valid;
  logic                       r_frame;

  ssr_ce_tracker u_trk (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_ce     (ce_i),
    .o_phase  (w_phase),
    .o_locked (w_locked),
    .o_viol   (w_viol),
    .o_err    (w_err)
  );

  assign w_hit = w_locked && !w_viol;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_a <= '0;
      r_hold_b <= '0;
      r_dat    <= '0;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
    end else if (!w_hit) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      case (w_phase)
        2'd1: begin
          r_hold_a <= dat_i;
          // r_valid low here means no B was captured in this lock yet
          r_dat    <= r_valid ? r_hold_b[5:2] : '0;
          r_frame  <= 1'b0;
        end
        2'd2: begin
          r_hold_b <= dat_i;
          r_dat    <= r_hold_a[3:0];
          r_frame  <= 1'b1;
          r_valid  <= 1'b1;
        end
        default: begin
          r_dat   <= {r_hold_b[1:0], r_hold_a[5:4]};
          r_frame <= 1'b0;
        end
      endcase
    end
  end

  assign dat_o   = r_dat;
  assign valid_o = r_valid;
  assign frame_o = r_frame;
  assign err_o   = w_err;

endmodule

// File: tb/tb_ssr6_to_ssr4_gearbox.sv
// Bench for ssr6_to_ssr4_gearbox: serial-model scoreboard plus per-scenario checks.
module tb_ssr6_to_ssr4_gearbox;
  import ssr_pkg::*;

  typedef logic [5:0][12:0] grp_t;
  typedef logic [3:0][12:0] word_t;
  typedef struct {
    word_t dat;
    logic  frame;
  } exp_t;

  logic  clk_i;
  logic  rst_i;
  logic  ce_i;
  grp_t  dat_i;
  word_t dat_o;
  logic  valid_o;
  logic  frame_o;
  logic  err_o;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  ssr6_to_ssr4_gearbox #(.NBITS(13)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ce_i    (ce_i),
    .dat_i   (dat_i),
    .dat_o   (dat_o),
    .valid_o (valid_o),
    .frame_o (frame_o),
    .err_o   (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic grp_t rand_grp();
    grp_t g;
    for (int i = 0; i < 6; i++) g[i] = 13'($urandom);
    return g;
  endfunction

  // Serial reference: 12 samples A0..A5,B0..B5 cut into three 4-sample words.
  task automatic push_group(input grp_t a, input grp_t b);
    logic [12:0] s[12];
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      s[i]     = a[i];
      s[i + 6] = b[i];
    end
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) e.dat[j] = s[4 * k + j];
      e.frame = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  // One clock of stimulus; outputs are scoreboarded at the following negedge.
  task automatic cyc(input logic ce, input grp_t d);
    exp_t e;
    ce_i  = ce;
    dat_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: valid_o=1 dat_o=%h, required no valid word", dat_o);
      end else begin
        e = exp_q.pop_front();
        if (dat_o !== e.dat || frame_o !== e.frame) begin
          n_bad++;
          $display("FAIL sb_data: dat_o=%h frame_o=%b, required dat_o=%h frame_o=%b",
                   dat_o, frame_o, e.dat, e.frame);
        end
      end
    end else if (dat_o !== '0 || frame_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_zero: valid_o=%b dat_o=%h frame_o=%b, required dat_o=0 frame_o=0",
               valid_o, dat_o, frame_o);
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    cyc(1'b1, '0);
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_group(input grp_t a, input grp_t b);
    cyc(1'b0, rand_grp());
    cyc(1'b1, a);
    push_group(a, b);
    cyc(1'b1, b);
  endtask

  // Flush the last group's remaining two words, then reset.
  task automatic drain_and_reset();
    cyc(1'b0, rand_grp());
    cyc(1'b1, rand_grp());
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    apply_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (valid_o !== 1'b0 || frame_o !== 1'b0 || err_o !== 1'b0 || dat_o !== '0) begin
      n_bad++;
      $display("FAIL rst_out: valid=%b frame=%b err=%b dat=%h, required all 0",
               valid_o, frame_o, err_o, dat_o);
    end
    n_vec++;
    if (dut.u_trk.r_state !== UNLOCKED || dut.u_trk.r_phase !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_state: state=%0d phase=%0d, required UNLOCKED/0",
               dut.u_trk.r_state, dut.u_trk.r_phase);
    end
  endtask

  task automatic test_basic();
    grp_t a, b;
    for (int i = 0; i < 6; i++) begin
      a[i] = 13'(i);
      b[i] = 13'(i + 6);
    end
    apply_reset();
    cyc(1'b0, rand_grp());
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_bad++; $display("FAIL basic_lockclk: valid_o=%b, required 0", valid_o);
    end
    cyc(1'b1, a);
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_bad++; $display("FAIL basic_aclk: valid_o=%b, required 0", valid_o);
    end
    push_group(a, b);
    cyc(1'b1, b);
    n_vec++;
    if (valid_o !== 1'b1 || frame_o !== 1'b1 || dat_o[0] !== 13'd0) begin
      n_bad++;
      $display("FAIL basic_latency: valid=%b frame=%b dat0=%0d, required 1/1/0",
               valid_o, frame_o, dat_o[0]);
    end
    cyc(1'b0, rand_grp());
    n_vec++;
    if (valid_o !== 1'b1 || frame_o !== 1'b0 || dat_o[3] !== 13'd7) begin
      n_bad++;
      $display("FAIL basic_w1: valid=%b frame=%b dat3=%0d, required 1/0/7", valid_o, frame_o, dat_o[3]);
    end
    cyc(1'b1, rand_grp());
    n_vec++;
    if (valid_o !== 1'b1 || dat_o[0] !== 13'd8 || dat_o[3] !== 13'd11) begin
      n_bad++;
      $display("FAIL basic_w2: valid=%b dat0=%0d dat3=%0d, required 1/8/11", valid_o, dat_o[0], dat_o[3]);
    end
    apply_reset();
  endtask

  task automatic test_random();
    grp_t a, b;
    int gaps = 0;
    int errs = 0;
    apply_reset();
    for (int g = 0; g < 100; g++) begin
      a = rand_grp();
      b = rand_grp();
      cyc(1'b0, rand_grp());
      if (g > 0 && valid_o !== 1'b1) gaps++;
      if (err_o !== 1'b0) errs++;
      cyc(1'b1, a);
      if (g > 0 && valid_o !== 1'b1) gaps++;
      if (err_o !== 1'b0) errs++;
      push_group(a, b);
      cyc(1'b1, b);
      if (valid_o !== 1'b1) gaps++;
      if (err_o !== 1'b0) errs++;
    end
    n_vec++;
    if (gaps != 0) begin
      n_bad++; $display("FAIL rand_valid_gaps: %0d gap clocks, required 0", gaps);
    end
    n_vec++;
    if (errs != 0) begin
      n_bad++; $display("FAIL rand_err: err_o high on %0d clocks, required 0", errs);
    end
    drain_and_reset();
  endtask

  task automatic test_ce_error();
    grp_t a, b;
    apply_reset();
    send_group(rand_grp(), rand_grp());
    send_group(rand_grp(), rand_grp());
    cyc(1'b1, rand_grp());
    n_vec++;
    if (err_o !== 1'b1 || valid_o !== 1'b0 || dat_o !== '0) begin
      n_bad++;
      $display("FAIL err_hit: err=%b valid=%b dat=%h, required 1/0/0", err_o, valid_o, dat_o);
    end
    exp_q.delete();
    cyc(1'b1, rand_grp());
    n_vec++;
    if (err_o !== 1'b1 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL err_sticky: err=%b valid=%b, required 1/0", err_o, valid_o);
    end
    a = rand_grp();
    b = rand_grp();
    cyc(1'b0, rand_grp());
    cyc(1'b1, a);
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_bad++; $display("FAIL err_relock_early: valid_o=%b, required 0", valid_o);
    end
    push_group(a, b);
    cyc(1'b1, b);
    n_vec++;
    if (valid_o !== 1'b1 || frame_o !== 1'b1 || err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_relock: valid=%b frame=%b err=%b, required 1/1/1", valid_o, frame_o, err_o);
    end
    drain_and_reset();
    n_vec++;
    if (err_o !== 1'b0) begin
      n_bad++; $display("FAIL err_clear: err_o=%b after reset, required 0", err_o);
    end
  endtask

  task automatic test_stuck_low();
    apply_reset();
    cyc(1'b0, rand_grp());
    cyc(1'b0, rand_grp());
    n_vec++;
    if (err_o !== 1'b1 || dut.u_trk.r_state !== UNLOCKED) begin
      n_bad++;
      $display("FAIL stuck0_err: err=%b state=%0d, required 1/UNLOCKED", err_o, dut.u_trk.r_state);
    end
    cyc(1'b1, rand_grp());
    cyc(1'b1, rand_grp());
    n_vec++;
    if (valid_o !== 1'b0 || dut.u_trk.r_state !== UNLOCKED) begin
      n_bad++;
      $display("FAIL stuck0_norelock: valid=%b state=%0d, required 0/UNLOCKED",
               valid_o, dut.u_trk.r_state);
    end
    apply_reset();
  endtask

  task automatic test_stuck_high();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, rand_grp());
      n_vec++;
      if (valid_o !== 1'b0 || err_o !== 1'b0 || dat_o !== '0) begin
        n_bad++;
        $display("FAIL stuck1_c%0d: valid=%b err=%b dat=%h, required 0/0/0", i, valid_o, err_o, dat_o);
      end
    end
    send_group(rand_grp(), rand_grp());
    n_vec++;
    if (valid_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL stuck1_lock: valid=%b err=%b, required 1/0", valid_o, err_o);
    end
    drain_and_reset();
  endtask

  task automatic test_mid_reset();
    grp_t stale;
    for (int i = 0; i < 6; i++) stale[i] = 13'h1555;
    apply_reset();
    send_group(rand_grp(), rand_grp());
    cyc(1'b0, rand_grp());
    cyc(1'b1, stale);
    rst_i = 1'b1;
    cyc(1'b1, rand_grp());
    rst_i = 1'b0;
    n_vec++;
    if (valid_o !== 1'b0 || frame_o !== 1'b0 || err_o !== 1'b0 || dat_o !== '0 ||
        dut.u_trk.r_state !== UNLOCKED) begin
      n_bad++;
      $display("FAIL midrst: valid=%b frame=%b err=%b dat=%h state=%0d, required all 0/UNLOCKED",
               valid_o, frame_o, err_o, dat_o, dut.u_trk.r_state);
    end
    exp_q.delete();
    send_group(rand_grp(), rand_grp());
    send_group(rand_grp(), rand_grp());
    drain_and_reset();
  endtask

  task automatic test_extremes();
    grp_t a, b;
    apply_reset();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 6; i++) begin
        a[i] = (((i + g) % 2) == 0) ? 13'h0FFF : 13'h1000;
        b[i] = (((i + g) % 2) == 0) ? 13'h1000 : 13'h0FFF;
      end
      send_group(a, b);
    end
    n_vec++;
    if (dat_o[0] !== 13'h1000 || dat_o[1] !== 13'h0FFF) begin
      n_bad++;
      $display("FAIL extreme_sign: dat0=%h dat1=%h, required 1000/0fff", dat_o[0], dat_o[1]);
    end
    drain_and_reset();
  endtask

  initial begin
    rst_i = 1'b1;
    ce_i  = 1'b1;
    dat_i = '0;
    test_reset();
    test_basic();
    test_random();
    test_ce_error();
    test_stuck_low();
    test_stuck_high();
    test_mid_reset();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
